// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : control FSM encoding (IDLE, SHIFT, DONE), 2 bits wide
//   DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out (set when a < b + bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, processed LSB first,
// one bit per clock, through a single full-subtractor cell.
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      operation request (taken in IDLE or DONE only)
//   A      in  WIDTH  minuend, captured on an accepted start
//   B      in  WIDTH  subtrahend, captured on an accepted start
//   Bin    in  1      borrow-in, captured on an accepted start
//   busy   out 1      high while in SHIFT
//   done   out 1      one-cycle pulse in DONE; D/Bout were just updated
//   D      out WIDTH  registered difference, held until the next completion
//   Bout   out 1      registered borrow-out beyond the MSB, held like D
//
// Handshake: a request is accepted on any rising edge where start=1 while
// the FSM is in IDLE or DONE; operands are captured on that same edge and
// may change afterwards. busy is then high for exactly WIDTH cycles, during
// which start is ignored (no queueing). done is high for exactly one cycle
// following the completion edge; a start seen during that cycle is accepted,
// giving back-to-back throughput of one result every WIDTH+1 cycles.
import serial_sub_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Only the upper WIDTH-1 difference bits are kept between cycles: on each
    // shift the oldest bit would drop off the bottom, so bit 0 is never needed.
    logic [WIDTH-2:0] d_sr_q, d_sr_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bout_q, bout_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] shift_word;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Difference word as it stands after this cycle's bit is shifted in.
    assign shift_word = {fs_d, d_sr_q};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    brw_d   = Bin;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = shift_word[WIDTH-1:1];
                brw_d  = fs_bout;
                if (cnt_q == '0) begin
                    res_d   = shift_word;
                    bout_d  = fs_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign D    = res_q;
    assign Bout = bout_q;

endmodule
